// File: rtl/password_lock_fsm.sv
// Keypad lock controller: verifies a 16-bit code, enforces a lockout after
// repeated failures, auto-relocks after a timeout and supports confirmed reprogramming.
module password_lock_fsm #(
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int          MAX_ATTEMPTS   = 3,
    parameter int          LOCKOUT_CYCLES = 500_000_000,
    parameter int          UNLOCK_CYCLES  = 1_000_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] password,
    input  logic        pw_valid,
    input  logic        lock_req,
    input  logic        prog_req,
    output logic        unlocked,
    output logic        alarm,
    output logic        error,
    output logic        prog_done,
    output logic [1:0]  attempts_left,
    output logic [2:0]  state
);

    localparam int             MAX_CYC     = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int             TW          = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0]  LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0]  UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
    localparam logic [1:0]     MAX_FAILS   = 2'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        S_LOCKED       = 3'd0,
        S_UNLOCKED     = 3'd1,
        S_LOCKOUT      = 3'd2,
        S_PROG_NEW     = 3'd3,
        S_PROG_CONFIRM = 3'd4
    } state_t;

    state_t          r_state;
    logic [15:0]     r_stored_code;
    logic [15:0]     r_candidate;
    logic [1:0]      r_fail_cnt;
    logic [TW-1:0]   r_timer;
    logic            r_unlocked;
    logic            r_alarm;
    logic            r_error;
    logic            r_prog_done;
    logic [1:0]      r_attempts_left;

    state_t          w_state_next;
    logic [15:0]     w_code_next;
    logic [15:0]     w_cand_next;
    logic [1:0]      w_fail_next;
    logic [TW-1:0]   w_timer_next;
    logic            w_error_evt;
    logic            w_commit_evt;
    logic [2:0]      w_fail_inc;
    logic            w_unlocked_next;
    logic            w_alarm_next;
    logic [1:0]      w_attempts_next;

    assign w_fail_inc = {1'b0, r_fail_cnt} + 3'd1;

    // State and datapath registers; outputs are registered from next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_LOCKED;
            r_stored_code   <= DEFAULT_CODE;
            r_candidate     <= 16'h0000;
            r_fail_cnt      <= 2'd0;
            r_timer         <= '0;
            r_unlocked      <= 1'b0;
            r_alarm         <= 1'b0;
            r_error         <= 1'b0;
            r_prog_done     <= 1'b0;
            r_attempts_left <= MAX_FAILS;
        end else begin
            r_state         <= w_state_next;
            r_stored_code   <= w_code_next;
            r_candidate     <= w_cand_next;
            r_fail_cnt      <= w_fail_next;
            r_timer         <= w_timer_next;
            r_unlocked      <= w_unlocked_next;
            r_alarm         <= w_alarm_next;
            r_error         <= w_error_evt;
            r_prog_done     <= w_commit_evt;
            r_attempts_left <= w_attempts_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_stored_code;
        w_cand_next  = r_candidate;
        w_fail_next  = r_fail_cnt;
        w_timer_next = r_timer;
        w_error_evt  = 1'b0;
        w_commit_evt = 1'b0;
        case (r_state)
            S_LOCKED: begin
                if (pw_valid) begin
                    if (password == r_stored_code) begin
                        w_state_next = S_UNLOCKED;
                        w_fail_next  = 2'd0;
                        w_timer_next = UNLOCK_LOAD;
                    end else begin
                        w_error_evt = 1'b1;
                        if (w_fail_inc >= {1'b0, MAX_FAILS}) begin
                            w_fail_next  = MAX_FAILS;
                            w_state_next = S_LOCKOUT;
                            w_timer_next = LOCK_LOAD;
                        end else begin
                            w_fail_next = w_fail_inc[1:0];
                        end
                    end
                end
            end
            S_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_state_next = S_LOCKED;
                    w_fail_next  = 2'd0;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            S_UNLOCKED: begin
                if (lock_req || (r_timer == '0)) begin
                    w_state_next = S_LOCKED;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                    if (prog_req) begin
                        w_state_next = S_PROG_NEW;
                    end
                end
            end
            S_PROG_NEW: begin
                if (lock_req) begin
                    w_state_next = S_LOCKED;
                    w_cand_next  = 16'h0000;
                end else if (pw_valid) begin
                    w_cand_next  = password;
                    w_state_next = S_PROG_CONFIRM;
                end
            end
            S_PROG_CONFIRM: begin
                if (lock_req) begin
                    w_state_next = S_LOCKED;
                    w_cand_next  = 16'h0000;
                end else if (pw_valid) begin
                    if (password == r_candidate) begin
                        w_code_next  = r_candidate;
                        w_commit_evt = 1'b1;
                    end else begin
                        w_error_evt = 1'b1;
                    end
                    w_state_next = S_UNLOCKED;
                    w_timer_next = UNLOCK_LOAD;
                    w_cand_next  = 16'h0000;
                end
            end
            default: begin
                w_state_next = S_LOCKED;
            end
        endcase
    end

    always_comb begin
        w_unlocked_next = (w_state_next == S_UNLOCKED);
        w_alarm_next    = (w_state_next == S_LOCKOUT);
        w_attempts_next = MAX_FAILS - w_fail_next;
    end

    assign unlocked      = r_unlocked;
    assign alarm         = r_alarm;
    assign error         = r_error;
    assign prog_done     = r_prog_done;
    assign attempts_left = r_attempts_left;
    assign state         = r_state;

endmodule

// File: tb/tb_password_lock_fsm.sv
// Scoreboard bench for password_lock_fsm: directed stimulus pushes the expected
// post-edge outputs, a monitor pops and compares one entry per clock.
module tb_password_lock_fsm;

    logic        clk;
    logic        reset;
    logic [15:0] password;
    logic        pw_valid;
    logic        lock_req;
    logic        prog_req;
    logic        unlocked;
    logic        alarm;
    logic        error;
    logic        prog_done;
    logic [1:0]  attempts_left;
    logic [2:0]  state;

    password_lock_fsm #(
        .DEFAULT_CODE   (16'h1234),
        .MAX_ATTEMPTS   (3),
        .LOCKOUT_CYCLES (8),
        .UNLOCK_CYCLES  (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .password      (password),
        .pw_valid      (pw_valid),
        .lock_req      (lock_req),
        .prog_req      (prog_req),
        .unlocked      (unlocked),
        .alarm         (alarm),
        .error         (error),
        .prog_done     (prog_done),
        .attempts_left (attempts_left),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       u;
        logic       a;
        logic       e;
        logic       d;
        logic [1:0] al;
        logic [2:0] st;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: every clock the DUT presents a fresh registered output set.
    always @(posedge clk) begin
        #3;
        if (sb_q.size() != 0) begin
            mon_x = sb_q.pop_front();
            n_checks++;
            if ({unlocked, alarm, error, prog_done, attempts_left, state} !==
                {mon_x.u, mon_x.a, mon_x.e, mon_x.d, mon_x.al, mon_x.st}) begin
                n_fail++;
                $display("FAIL %s: got u=%b a=%b e=%b d=%b al=%0d st=%0d, expected u=%b a=%b e=%b d=%b al=%0d st=%0d",
                         mon_x.nm, unlocked, alarm, error, prog_done, attempts_left, state,
                         mon_x.u, mon_x.a, mon_x.e, mon_x.d, mon_x.al, mon_x.st);
            end else begin
                $display("ok   %s: u=%b a=%b e=%b d=%b al=%0d st=%0d",
                         mon_x.nm, unlocked, alarm, error, prog_done, attempts_left, state);
            end
        end
    end

    task automatic cyc(input string nm, input logic rst, input logic pv, input logic [15:0] pw,
                       input logic lr, input logic pr,
                       input logic eu, input logic ea, input logic ee, input logic ed,
                       input logic [1:0] eal, input logic [2:0] est);
        exp_t x;
        reset    = rst;
        pw_valid = pv;
        password = pw;
        lock_req = lr;
        prog_req = pr;
        x.nm = nm; x.u = eu; x.a = ea; x.e = ee; x.d = ed; x.al = eal; x.st = est;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        pw_valid = 1'b0;
        lock_req = 1'b0;
        prog_req = 1'b0;
    endtask

    task automatic idle(input string nm, input logic [1:0] eal, input logic [2:0] est);
        cyc(nm, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, est == 3'd1, est == 3'd2, 1'b0, 1'b0, eal, est);
    endtask

    task automatic enter(input string nm, input logic [15:0] code, input logic ee,
                         input logic [1:0] eal, input logic [2:0] est);
        cyc(nm, 1'b0, 1'b1, code, 1'b0, 1'b0, est == 3'd1, est == 3'd2, ee, 1'b0, eal, est);
    endtask

    task automatic ctl(input string nm, input logic lr, input logic pr,
                       input logic [1:0] eal, input logic [2:0] est);
        cyc(nm, 1'b0, 1'b0, 16'h0000, lr, pr, est == 3'd1, est == 3'd2, 1'b0, 1'b0, eal, est);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; password = 16'h0000; pw_valid = 1'b0; lock_req = 1'b0; prog_req = 1'b0;
        cyc("reset0", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0);
        cyc("reset1", 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0);

        // Default code unlocks, then auto-relock after 16 cycles.
        enter("unlock_default", 16'h1234, 1'b0, 2'd3, 3'd1);
        enter("pw_ignored_unlocked", 16'h0000, 1'b0, 2'd3, 3'd1);
        for (int i = 0; i < 14; i++) idle("unlocked_hold", 2'd3, 3'd1);
        idle("auto_relock", 2'd3, 3'd0);

        // Three failures -> 8-cycle lockout with inputs ignored.
        enter("bad1", 16'h0000, 1'b1, 2'd2, 3'd0);
        idle("after_bad1", 2'd2, 3'd0);
        enter("bad2", 16'h0000, 1'b1, 2'd1, 3'd0);
        idle("after_bad2", 2'd1, 3'd0);
        enter("bad3_lockout", 16'h0000, 1'b1, 2'd0, 3'd2);
        enter("lockout_ignore_pw", 16'h1234, 1'b0, 2'd0, 3'd2);
        ctl("lockout_ignore_lock", 1'b1, 1'b0, 2'd0, 3'd2);
        ctl("lockout_ignore_prog", 1'b0, 1'b1, 2'd0, 3'd2);
        for (int i = 0; i < 4; i++) idle("lockout_hold", 2'd0, 3'd2);
        idle("lockout_exit", 2'd3, 3'd0);

        // A correct code clears a partial fail count.
        enter("bad_once", 16'h0000, 1'b1, 2'd2, 3'd0);
        enter("good_clears", 16'h1234, 1'b0, 2'd3, 3'd1);
        ctl("lock_req", 1'b1, 1'b0, 2'd3, 3'd0);

        // Reprogram to BEEF.
        enter("unlock", 16'h1234, 1'b0, 2'd3, 3'd1);
        ctl("prog_req", 1'b0, 1'b1, 2'd3, 3'd3);
        enter("prog_new", 16'hBEEF, 1'b0, 2'd3, 3'd4);
        cyc("prog_commit", 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 3'd1);
        ctl("relock", 1'b1, 1'b0, 2'd3, 3'd0);
        enter("old_code_rejected", 16'h1234, 1'b1, 2'd2, 3'd0);
        enter("new_code_unlocks", 16'hBEEF, 1'b0, 2'd3, 3'd1);
        ctl("relock2", 1'b1, 1'b0, 2'd3, 3'd0);

        // Reset restores the default; failed confirm leaves code alone.
        cyc("reset_restore", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0);
        enter("default_again", 16'h1234, 1'b0, 2'd3, 3'd1);
        ctl("prog_req2", 1'b0, 1'b1, 2'd3, 3'd3);
        enter("prog_new2", 16'hBEEF, 1'b0, 2'd3, 3'd4);
        enter("confirm_mismatch", 16'hBEE0, 1'b1, 2'd3, 3'd1);
        ctl("relock3", 1'b1, 1'b0, 2'd3, 3'd0);
        enter("code_unchanged", 16'h1234, 1'b0, 2'd3, 3'd1);

        // Priorities, aborts and reset in the middle of things.
        ctl("lock_and_prog", 1'b1, 1'b1, 2'd3, 3'd0);
        enter("unlock4", 16'h1234, 1'b0, 2'd3, 3'd1);
        ctl("prog_req4", 1'b0, 1'b1, 2'd3, 3'd3);
        cyc("abort_new", 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0);
        enter("unlock5", 16'h1234, 1'b0, 2'd3, 3'd1);
        ctl("prog_req5", 1'b0, 1'b1, 2'd3, 3'd3);
        enter("prog_new5", 16'hBEEF, 1'b0, 2'd3, 3'd4);
        cyc("abort_confirm", 1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0);
        enter("cand_discarded", 16'hBEEF, 1'b1, 2'd2, 3'd0);
        enter("unlock6", 16'h1234, 1'b0, 2'd3, 3'd1);
        ctl("prog_req6", 1'b0, 1'b1, 2'd3, 3'd3);
        enter("prog_new6", 16'hBEEF, 1'b0, 2'd3, 3'd4);
        cyc("reset_in_confirm", 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0);
        enter("beef_not_stored", 16'hBEEF, 1'b1, 2'd2, 3'd0);
        enter("bad_a", 16'h0000, 1'b1, 2'd1, 3'd0);
        enter("bad_b_lockout", 16'h0000, 1'b1, 2'd0, 3'd2);
        idle("lockout_mid", 2'd0, 3'd2);
        cyc("reset_in_lockout", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0);
        enter("default_after_reset", 16'h1234, 1'b0, 2'd3, 3'd1);

        for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(posedge clk);
        #5;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
